strip_row_emitter: RTL

//  Producer side of the vertical-strip interface. Takes a 1-bit raster pixel stream (valid/ready, SOF-marked).

---
 rtl/strip_row_emitter.sv | 108 ++++++++++
 1 files changed

// File: rtl/strip_row_emitter.sv
// rtl/strip_row_emitter.sv - extracts a fixed column window from a 1-bit raster stream
// and emits one strip beat per image row.
module strip_row_emitter #(
  parameter int IMG_W     = 300,
  parameter int IMG_H     = 200,
  parameter int COL_START = 0,
  parameter int STRIP_W   = 200,
  parameter int ROW_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               pix_data,
  input  logic               pix_sof,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [STRIP_W-1:0] row_data,
  output logic [ROW_W-1:0]   row_idx,
  output logic               row_last,
  output logic               frame_done,
  output logic               sync_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0]    COL_MAX = CW'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [CW-1:0]    WIN_LO  = CW'(COL_START);
  localparam logic [CW-1:0]    WIN_HI  = CW'(COL_START + STRIP_W - 1);
  localparam logic [CW:0]      WIN_SZ  = (CW+1)'(STRIP_W);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      col, col_eff;
  logic [ROW_W-1:0]   row, row_eff;
  logic [STRIP_W-1:0] sr, sr_nx;
  logic [CW:0]        win_off;
  logic               acc, take, in_win, col_end, frame_end, row_done;

  assign pix_ready = ~row_valid | row_ready;
  assign acc       = pix_valid & pix_ready;
  // An SOF beat always counts as pixel (0,0), whatever the current position.
  assign take      = acc & (pix_sof | (state == CAPTURE));
  assign col_eff   = pix_sof ? '0 : col;
  assign row_eff   = pix_sof ? '0 : row;
  // Wrapping subtraction makes columns left of the window look huge.
  assign win_off   = {1'b0, col_eff} - {1'b0, WIN_LO};
  assign in_win    = win_off < WIN_SZ;
  assign col_end   = col_eff == COL_MAX;
  assign frame_end = col_end & (row_eff == ROW_MAX);
  assign row_done  = in_win & (col_eff == WIN_HI);

  always_comb begin
    sr_nx = sr >> 1;
    sr_nx[STRIP_W-1] = pix_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (take) state_nx = frame_end ? IDLE : CAPTURE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      sr         <= '0;
      row_valid  <= 1'b0;
      row_data   <= '0;
      row_idx    <= '0;
      row_last   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= take & frame_end;
      if (take & pix_sof & (state == CAPTURE)) sync_err <= 1'b1;
      if (take) begin
        if (in_win) sr <= sr_nx;
        if (frame_end) begin
          col <= '0;
          row <= '0;
        end else if (col_end) begin
          col <= '0;
          row <= row_eff + 1'b1;
        end else begin
          col <= col_eff + 1'b1;
          row <= row_eff;
        end
      end
      // take implies pix_ready, so a new row never overwrites an unaccepted one.
      if (take & row_done) begin
        row_valid <= 1'b1;
        row_data  <= sr_nx;
        row_idx   <= row_eff;
        row_last  <= row_eff == ROW_MAX;
      end else if (row_ready) begin
        row_valid <= 1'b0;
      end
    end
  end

endmodule
